mult16_booth_seq: RTL and testbench

Multi-cycle signed 16x16 multiplier controller that sequences a single shared 16-bit carry-lookahead adder (`cla_adder16`) through radix-2 Booth recoding. It sits beside the ALU in the execute stage and serves multiply instructions. It accepts a start pulse, runs 16 add/subtract-and-shift iterations, then presents a 32-bit product plus a 16-bit-overflow exception flag with a one-cycle ready pulse.

---
 rtl/mult16_booth_seq.sv | 134 +++++++++++++
 tb/tb_mult16_booth_seq.sv | 161 ++++++++++++++++
 2 files changed

// File: rtl/mult16_booth_seq.sv
// Sequential signed 16x16 radix-2 Booth multiplier. One shared 16-bit CLA
// performs each iteration's add, subtract or pass-through.
module cla_adder16 (
    input  logic [15:0] in_a,
    input  logic [15:0] in_b,
    input  logic        c_in,
    output logic [15:0] sum,
    output logic        c_out
);
    logic [15:0] g, p, c;
    logic [3:0]  gg, gp;
    logic [4:0]  gc;

    assign g = in_a & in_b;
    assign p = in_a ^ in_b;

    always_comb begin
        gg = '0;
        gp = '0;
        c  = '0;
        for (int unsigned j = 0; j < 4; j++) begin
            gg[j] = g[4*j+3] | (p[4*j+3] & g[4*j+2]) | (p[4*j+3] & p[4*j+2] & g[4*j+1])
                  | (p[4*j+3] & p[4*j+2] & p[4*j+1] & g[4*j]);
            gp[j] = &p[4*j +: 4];
        end
        // Second-level lookahead across the four 4-bit groups.
        gc[0] = c_in;
        gc[1] = gg[0] | (gp[0] & c_in);
        gc[2] = gg[1] | (gp[1] & gg[0]) | (gp[1] & gp[0] & c_in);
        gc[3] = gg[2] | (gp[2] & gg[1]) | (gp[2] & gp[1] & gg[0]) | (gp[2] & gp[1] & gp[0] & c_in);
        gc[4] = gg[3] | (gp[3] & gg[2]) | (gp[3] & gp[2] & gg[1]) | (gp[3] & gp[2] & gp[1] & gg[0])
              | (gp[3] & gp[2] & gp[1] & gp[0] & c_in);
        for (int unsigned j = 0; j < 4; j++) begin
            c[4*j]   = gc[j];
            c[4*j+1] = g[4*j] | (p[4*j] & gc[j]);
            c[4*j+2] = g[4*j+1] | (p[4*j+1] & g[4*j]) | (p[4*j+1] & p[4*j] & gc[j]);
            c[4*j+3] = g[4*j+2] | (p[4*j+2] & g[4*j+1]) | (p[4*j+2] & p[4*j+1] & g[4*j])
                     | (p[4*j+2] & p[4*j+1] & p[4*j] & gc[j]);
        end
    end

    assign sum   = p ^ c;
    assign c_out = gc[4];
endmodule

module mult16_booth_seq (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        ctrl_mult,
    input  logic [15:0] data_operandA,
    input  logic [15:0] data_operandB,
    output logic [31:0] data_result,
    output logic        data_exception,
    output logic        data_resultRDY,
    output logic        busy
);
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t      state_q;
    logic [15:0] m_q;
    logic [32:0] pr_q, pr_d;
    logic [3:0]  cnt_q;
    logic [31:0] result_q;
    logic        exc_q, exc_d;

    logic [15:0] add_a, add_b, add_sum;
    logic        add_cin, add_cout, ovf, s;

    cla_adder16 u_cla (
        .in_a  (add_a),
        .in_b  (add_b),
        .c_in  (add_cin),
        .sum   (add_sum),
        .c_out (add_cout)
    );

    always_comb begin
        add_a   = pr_q[32:17];
        add_b   = '0;
        add_cin = 1'b0;
        unique case (pr_q[1:0])
            2'b01:   add_b = m_q;
            2'b10: begin
                add_b   = ~m_q;
                add_cin = 1'b1;
            end
            default: add_b = '0;
        endcase
        // Overflow-corrected sign keeps the shifted-in bit equal to the true 17-bit sign.
        ovf   = (add_a[15] == add_b[15]) && (add_sum[15] != add_a[15]);
        s     = add_sum[15] ^ ovf;
        pr_d  = {s, add_sum, pr_q[16:1]};
        exc_d = ~((&pr_d[32:16]) | ~(|pr_d[32:16]));
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= IDLE;
            m_q      <= '0;
            pr_q     <= '0;
            cnt_q    <= '0;
            result_q <= '0;
            exc_q    <= 1'b0;
        end else begin
            unique case (state_q)
                RUN: begin
                    pr_q  <= pr_d;
                    cnt_q <= cnt_q + 4'd1;
                    if (cnt_q == 4'd15) begin
                        // Product is captured on the last iteration so it is valid throughout DONE.
                        result_q <= pr_d[32:1];
                        exc_q    <= exc_d;
                        state_q  <= DONE;
                    end
                end
                default: begin
                    if (ctrl_mult) begin
                        m_q     <= data_operandA;
                        pr_q    <= {16'h0000, data_operandB, 1'b0};
                        cnt_q   <= '0;
                        state_q <= RUN;
                    end else begin
                        state_q <= IDLE;
                    end
                end
            endcase
        end
    end

    assign data_result    = result_q;
    assign data_exception = exc_q;
    assign data_resultRDY = (state_q == DONE);
    assign busy           = (state_q == RUN);
endmodule

// File: tb/tb_mult16_booth_seq.sv
// Scoreboard bench for mult16_booth_seq: directed operands, expected products
// and ready cycles queued by the driver, checked by an independent monitor.
module tb_mult16_booth_seq;
    logic        clock = 1'b0;
    logic        reset_n = 1'b0;
    logic        ctrl_mult = 1'b0;
    logic [15:0] data_operandA = '0;
    logic [15:0] data_operandB = '0;
    logic [31:0] data_result;
    logic        data_exception;
    logic        data_resultRDY;
    logic        busy;

    mult16_booth_seq dut (
        .clock          (clock),
        .reset_n        (reset_n),
        .ctrl_mult      (ctrl_mult),
        .data_operandA  (data_operandA),
        .data_operandB  (data_operandB),
        .data_result    (data_result),
        .data_exception (data_exception),
        .data_resultRDY (data_resultRDY),
        .busy           (busy)
    );

    initial forever #5 clock = ~clock;

    typedef struct {
        logic [31:0] res;
        logic        exc;
        int unsigned due;
    } exp_t;

    exp_t        sb[$];
    int unsigned cyc = 0;
    int unsigned busy_cnt = 0;
    int unsigned passed = 0;
    int unsigned total = 0;

    always @(posedge clock) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        total++;
        if (got === want) passed++;
        else $display("FAIL %s: got %h expected %h", name, got, want);
    endtask

    always @(negedge clock) begin
        if (busy) busy_cnt++;
        if (data_resultRDY) begin
            if (sb.size() == 0) begin
                check("stray_ready", 32'd1, 32'd0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("result", data_result, e.res);
                check("exception", {31'd0, data_exception}, {31'd0, e.exc});
                check("ready_cycle", cyc, e.due);
            end
        end
    end

    // Called just before a rising edge that accepts the start; ready is
    // expected 16 edges after that accepting edge (the 17th cycle).
    task automatic start_op(input logic [15:0] a, input logic [15:0] b,
                            input logic [31:0] res, input logic exc);
        exp_t e;
        data_operandA = a;
        data_operandB = b;
        ctrl_mult     = 1'b1;
        @(posedge clock);
        #1;
        e.res = res;
        e.exc = exc;
        e.due = cyc + 16;
        sb.push_back(e);
        ctrl_mult     = 1'b0;
        data_operandA = 16'($urandom);
        data_operandB = 16'($urandom);
    endtask

    task automatic wait_idle();
        int unsigned n = 0;
        while ((sb.size() != 0 || busy || data_resultRDY) && n < 60) begin
            @(negedge clock);
            n++;
        end
        if (n >= 60) begin
            check("timeout", 32'd1, 32'd0);
            sb.delete();
        end
        @(negedge clock);
    endtask

    initial begin
        repeat (2) @(negedge clock);
        check("rst_result", data_result, 32'h0);
        check("rst_flags", {29'd0, data_exception, data_resultRDY, busy}, 32'h0);
        reset_n = 1'b1;
        @(negedge clock);

        start_op(16'd3, 16'd4, 32'h0000000C, 1'b0);
        wait_idle();
        @(negedge clock); start_op(-16'sd3, 16'd7, 32'hFFFFFFEB, 1'b0);
        wait_idle();
        @(negedge clock); start_op(16'd300, 16'd300, 32'h00015F90, 1'b1);
        wait_idle();
        @(negedge clock); start_op(16'h8000, 16'h8000, 32'h40000000, 1'b1);
        wait_idle();
        @(negedge clock); start_op(16'h0000, 16'h8000, 32'h00000000, 1'b0);
        wait_idle();
        @(negedge clock); start_op(16'h8000, 16'h0001, 32'hFFFF8000, 1'b0);
        wait_idle();
        @(negedge clock); start_op(16'h7FFF, 16'h7FFF, 32'h3FFF0001, 1'b1);
        wait_idle();

        // Start pulses mid-run must be ignored.
        busy_cnt = 0;
        @(negedge clock); start_op(16'd6, 16'd7, 32'd42, 1'b0);
        repeat (4) @(negedge clock);
        data_operandA = 16'd100; data_operandB = 16'd100; ctrl_mult = 1'b1;
        @(negedge clock); ctrl_mult = 1'b0;
        repeat (4) @(negedge clock);
        data_operandA = 16'd9; data_operandB = 16'd9; ctrl_mult = 1'b1;
        @(negedge clock); ctrl_mult = 1'b0;
        wait_idle();
        check("busy_cycles", busy_cnt, 32'd16);

        // Back-to-back: second start issued during the DONE cycle.
        @(negedge clock); start_op(16'd2, 16'd3, 32'd6, 1'b0);
        begin
            int unsigned n = 0;
            while (!data_resultRDY && n < 40) begin
                @(negedge clock);
                n++;
            end
            if (n >= 40) check("b2b_ready_timeout", 32'd1, 32'd0);
        end
        start_op(16'hFFFF, 16'hFFFF, 32'd1, 1'b0);
        repeat (8) @(negedge clock);
        check("hold_between", data_result, 32'd6);
        wait_idle();

        // Asynchronous reset in the middle of a run.
        @(negedge clock); start_op(16'd9, 16'd9, 32'd81, 1'b0);
        repeat (7) @(negedge clock);
        #2 reset_n = 1'b0;
        #1;
        sb.delete();
        check("abort_result", data_result, 32'h0);
        check("abort_flags", {29'd0, data_exception, data_resultRDY, busy}, 32'h0);
        repeat (2) @(negedge clock);
        reset_n = 1'b1;
        repeat (20) @(negedge clock);
        start_op(16'd5, 16'd5, 32'd25, 1'b0);
        wait_idle();

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
